// File: rtl/jump_stall_ctrl.sv
// jump_stall_ctrl: ID-stage control-hazard sequencer.
// It handles JAL and JALR decoded in ID, and taken branches resolved in EX.
// For each accepted request it emits a one-cycle PC redirect with its target.
// It then holds IF/ID (pipe_valid=0) for a per-type number of cycles.
// After the hold it gives a one-cycle release.
//
// Handshake: redirect_valid is a one-cycle strobe. redirect_pc and IF_ID_flush
// are meaningful only while it is high, and the PC consumer must load
// redirect_pc on the same rising edge. There is no back-pressure on the strobe.
// pipe_hold freezes the STALL countdown and the RELEASE exit. It never blocks
// a redirect.
//
// Optional feature: define JUMP_STAT_EN to add the stall_cycles and
// redirect_count statistics outputs. Both counters saturate.
module jump_stall_ctrl #(
  parameter int DATAW      = 32,
  parameter int CNT_W      = 3,
  parameter int JAL_STALL  = 1,
  parameter int JALR_STALL = 2,
  parameter int BR_STALL   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDU_JAL_instr,
  input  logic             IDU_JALR_instr,
  input  logic [DATAW-1:0] IDU_PC_add_imme,
  input  logic [DATAW-1:0] IDU_jalr_target,
  input  logic             EXU_branch_taken,
  input  logic [DATAW-1:0] EXU_branch_target,
  input  logic             pipe_hold,
  output logic             pipe_valid,
  output logic             redirect_valid,
  output logic [DATAW-1:0] redirect_pc,
  output logic             IF_ID_flush,
  output logic             busy
`ifdef JUMP_STAT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      redirect_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] JAL_LOAD  = CNT_W'(JAL_STALL - 1);
  localparam logic [CNT_W-1:0] JALR_LOAD = CNT_W'(JALR_STALL - 1);
  localparam logic [CNT_W-1:0] BR_LOAD   = CNT_W'(BR_STALL - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept_br;
  logic             accept_j;
  logic [CNT_W-1:0] load_val;

  // Request arbitration: a taken branch wins anywhere.
  // ID jumps count only in IDLE, because in STALL/RELEASE their flags are stale decode.
  always_comb begin
    accept_br      = EXU_branch_taken;
    accept_j       = (state == IDLE) && !EXU_branch_taken &&
                     (IDU_JAL_instr || IDU_JALR_instr);
    redirect_valid = accept_br || accept_j;
    IF_ID_flush    = accept_br;
    redirect_pc    = '0;
    load_val       = '0;
    if (accept_br) begin
      redirect_pc = EXU_branch_target;
      load_val    = BR_LOAD;
    end else if (accept_j) begin
      if (IDU_JALR_instr) begin
        redirect_pc = IDU_jalr_target;
        load_val    = JALR_LOAD;
      end else begin
        redirect_pc = IDU_PC_add_imme;
        load_val    = JAL_LOAD;
      end
    end
    pipe_valid = (state != STALL) && !redirect_valid;
  end

  assign busy = (state != IDLE);

  // Sequencer: a redirect (re)loads the counter; otherwise step through STALL/RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (redirect_valid) begin
      cnt   <= load_val;
      state <= (load_val != '0) ? STALL : RELEASE;
    end else begin
      case (state)
        STALL: begin
          if (!pipe_hold) begin
            if (cnt <= CNT_W'(1)) begin
              cnt   <= '0;
              state <= RELEASE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JUMP_STAT_EN
  // Saturating statistics: pipe_valid-low cycles and redirect pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!pipe_valid && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (redirect_valid && redirect_count != 16'hFFFF)
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule
